// File: rtl/cfg_sequencer.sv
// Config-port sequencer: boots the default filter rule set, verifies it by readback,
// then passes host writes/reads to the register file. CFG_WRITE_LOCK_EN adds a host write lock.
module cfg_sequencer #(
  parameter int unsigned NUM_WORDS = 7,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_start,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_rd_valid,
  output logic              host_rd_ready,
  input  logic [ADDR_W-1:0] host_raddr,
  output logic              host_rd_resp_valid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_waddr,
  output logic [DATA_W-1:0] cfg_wdata,
  output logic [ADDR_W-1:0] cfg_raddr,
  input  logic [DATA_W-1:0] cfg_rdata,
  output logic              filter_hold,
  output logic              boot_done,
  output logic              boot_err,
`ifdef CFG_WRITE_LOCK_EN
  output logic [7:0]        lock_drop_cnt,
`endif
  output logic [ADDR_W-1:0] err_addr
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StBootWr, StBootVfy, StHost} state_e;

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic             verify_bad;
  logic             wr_blocked;

  function automatic logic [DATA_W-1:0] rom(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       rom = DATA_W'(32'hDEAD_BEEF);
      1:       rom = DATA_W'(32'h0000_CAFE);
      2:       rom = DATA_W'(32'h0000_0800);
      3:       rom = DATA_W'(32'h0000_0011);
      4:       rom = DATA_W'(32'h0A00_0100);
      5:       rom = DATA_W'(32'hFFFF_FFFC);
      6:       rom = DATA_W'(32'h0000_63DD);
      default: rom = '0;
    endcase
  endfunction

`ifdef CFG_WRITE_LOCK_EN
  localparam logic [ADDR_W-1:0] LockAddr = {ADDR_W{1'b1}};
  logic lock;
  assign wr_blocked = lock;
`else
  assign wr_blocked = 1'b0;
`endif

  assign host_wr_ready = (state == StHost);
  assign host_rd_ready = (state == StHost);
  assign boot_done     = (state == StHost);
  assign filter_hold   = (state != StHost);

  // Port drive is gated by rst_n so the register file sees no write while reset is held.
  always_comb begin
    cfg_we     = 1'b0;
    cfg_waddr  = '0;
    cfg_wdata  = '0;
    cfg_raddr  = '0;
    verify_bad = 1'b0;
    if (rst_n) begin
      unique case (state)
        StBootWr: begin
          cfg_we    = 1'b1;
          cfg_waddr = ADDR_W'(idx);
          cfg_wdata = rom(idx);
        end
        StBootVfy: begin
          cfg_raddr  = ADDR_W'(idx);
          verify_bad = (cfg_rdata != rom(idx));
        end
        StHost: begin
          cfg_we    = host_wr_valid && !wr_blocked;
          cfg_waddr = host_waddr;
          cfg_wdata = host_wdata;
          cfg_raddr = host_raddr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= StBootWr;
      idx                <= '0;
      host_rd_resp_valid <= 1'b0;
      host_rdata         <= '0;
      boot_err           <= 1'b0;
      err_addr           <= '0;
`ifdef CFG_WRITE_LOCK_EN
      lock               <= 1'b0;
      lock_drop_cnt      <= '0;
`endif
    end else begin
      host_rd_resp_valid <= 1'b0;
      unique case (state)
        StBootWr: begin
          if (idx == LastIdx) begin
            idx   <= '0;
            state <= StBootVfy;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        StBootVfy: begin
          if (verify_bad && !boot_err) begin
            boot_err <= 1'b1;
            err_addr <= ADDR_W'(idx);
          end
          if (idx == LastIdx) begin
            idx   <= '0;
            state <= StHost;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        StHost: begin
          if (host_rd_valid) begin
            host_rd_resp_valid <= 1'b1;
            host_rdata         <= cfg_rdata;
`ifdef CFG_WRITE_LOCK_EN
            if (host_raddr == LockAddr) host_rdata <= DATA_W'(lock);
`endif
          end
`ifdef CFG_WRITE_LOCK_EN
          if (host_wr_valid) begin
            if (lock) begin
              if (lock_drop_cnt != 8'hFF) lock_drop_cnt <= lock_drop_cnt + 8'd1;
            end else if (host_waddr == LockAddr && host_wdata[0]) begin
              lock <= 1'b1;
            end
          end
`endif
          if (boot_start) begin
            state    <= StBootWr;
            idx      <= '0;
            boot_err <= 1'b0;
            err_addr <= '0;
          end
        end
        default: state <= StBootWr;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer with a 7-entry register file model behind the config port.
// Lock checks are included when CFG_WRITE_LOCK_EN is defined.
module tb_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_start;
  logic        host_wr_valid, host_wr_ready;
  logic [3:0]  host_waddr;
  logic [31:0] host_wdata;
  logic        host_rd_valid, host_rd_ready;
  logic [3:0]  host_raddr;
  logic        host_rd_resp_valid;
  logic [31:0] host_rdata;
  logic        cfg_we;
  logic [3:0]  cfg_waddr, cfg_raddr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        filter_hold, boot_done, boot_err;
  logic [3:0]  err_addr;
`ifdef CFG_WRITE_LOCK_EN
  logic [7:0]  lock_drop_cnt;
`endif

  logic        corrupt;
  logic [31:0] regs [0:6];
  logic [31:0] rom_exp [0:6];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  cfg_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .boot_start         (boot_start),
    .host_wr_valid      (host_wr_valid),
    .host_wr_ready      (host_wr_ready),
    .host_waddr         (host_waddr),
    .host_wdata         (host_wdata),
    .host_rd_valid      (host_rd_valid),
    .host_rd_ready      (host_rd_ready),
    .host_raddr         (host_raddr),
    .host_rd_resp_valid (host_rd_resp_valid),
    .host_rdata         (host_rdata),
    .cfg_we             (cfg_we),
    .cfg_waddr          (cfg_waddr),
    .cfg_wdata          (cfg_wdata),
    .cfg_raddr          (cfg_raddr),
    .cfg_rdata          (cfg_rdata),
    .filter_hold        (filter_hold),
    .boot_done          (boot_done),
    .boot_err           (boot_err),
`ifdef CFG_WRITE_LOCK_EN
    .lock_drop_cnt      (lock_drop_cnt),
`endif
    .err_addr           (err_addr)
  );

  // Register file: combinational read, out-of-range reads return DEADBEEF, writes ignored.
  always_comb begin
    cfg_rdata = 32'hDEAD_BEEF;
    if (cfg_raddr < 4'd7) cfg_rdata = regs[cfg_raddr[2:0]];
    if (corrupt && cfg_raddr == 4'd3) cfg_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (cfg_we && cfg_waddr < 4'd7) regs[cfg_waddr[2:0]] <= cfg_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps n boot cycles from cycle 0, checking the config port each cycle.
  task automatic boot_run(input int n);
    for (int k = 0; k < n; k++) begin
      #1;
      if (k < 7) begin
        check("boot_we", 32'(cfg_we), 32'd1);
        check("boot_waddr", 32'(cfg_waddr), 32'(k));
        check("boot_wdata", cfg_wdata, rom_exp[k]);
      end else begin
        check("vfy_we", 32'(cfg_we), 32'd0);
        check("vfy_raddr", 32'(cfg_raddr), 32'(k - 7));
      end
      check("boot_hold", 32'(filter_hold), 32'd1);
      check("boot_done_lo", 32'(boot_done), 32'd0);
      check("boot_wr_rdy", 32'(host_wr_ready), 32'd0);
      check("boot_rd_rdy", 32'(host_rd_ready), 32'd0);
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(cfg_we), 32'd0);
    check({tag, "_waddr"}, 32'(cfg_waddr), 32'd0);
    check({tag, "_wdata"}, cfg_wdata, 32'd0);
    check({tag, "_raddr"}, 32'(cfg_raddr), 32'd0);
    check({tag, "_wrdy"}, 32'(host_wr_ready), 32'd0);
    check({tag, "_rrdy"}, 32'(host_rd_ready), 32'd0);
    check({tag, "_resp"}, 32'(host_rd_resp_valid), 32'd0);
    check({tag, "_rdata"}, host_rdata, 32'd0);
    check({tag, "_hold"}, 32'(filter_hold), 32'd1);
    check({tag, "_done"}, 32'(boot_done), 32'd0);
    check({tag, "_err"}, 32'(boot_err), 32'd0);
    check({tag, "_eaddr"}, 32'(err_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rom_exp = '{32'hDEAD_BEEF, 32'h0000_CAFE, 32'h0000_0800, 32'h0000_0011,
                32'h0A00_0100, 32'hFFFF_FFFC, 32'h0000_63DD};
    rst_n = 1'b0; boot_start = 1'b0; corrupt = 1'b0;
    host_wr_valid = 1'b0; host_waddr = '0; host_wdata = '0;
    host_rd_valid = 1'b0; host_raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    // Clean boot with a host write held from cycle 2.
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) begin
        host_wr_valid = 1'b1; host_waddr = 4'd6; host_wdata = 32'h0000_1F90;
      end
      #1;
      if (k < 7) begin
        check("b0_waddr", 32'(cfg_waddr), 32'(k));
        check("b0_wdata", cfg_wdata, rom_exp[k]);
      end else begin
        check("b0_we", 32'(cfg_we), 32'd0);
        check("b0_raddr", 32'(cfg_raddr), 32'(k - 7));
      end
      check("b0_wrdy", 32'(host_wr_ready), 32'd0);
      check("b0_hold", 32'(filter_hold), 32'd1);
      tick();
    end
    #1;
    check("c14_done", 32'(boot_done), 32'd1);
    check("c14_hold", 32'(filter_hold), 32'd0);
    check("c14_err", 32'(boot_err), 32'd0);
    check("c14_wrdy", 32'(host_wr_ready), 32'd1);
    check("c14_we", 32'(cfg_we), 32'd1);
    check("c14_waddr", 32'(cfg_waddr), 32'd6);
    check("c14_wdata", cfg_wdata, 32'h0000_1F90);
    tick();
    host_wr_valid = 1'b0;

    // Same-cycle write and read of address 4: read sees pre-write value.
    host_wr_valid = 1'b1; host_waddr = 4'd4; host_wdata = 32'hC0A8_0000;
    host_rd_valid = 1'b1; host_raddr = 4'd4;
    #1;
    check("rw_we", 32'(cfg_we), 32'd1);
    check("rw_raddr", 32'(cfg_raddr), 32'd4);
    check("rw_rrdy", 32'(host_rd_ready), 32'd1);
    tick();
    host_wr_valid = 1'b0;
    #1;
    check("rw_resp", 32'(host_rd_resp_valid), 32'd1);
    check("rw_old", host_rdata, 32'h0A00_0100);
    tick();
    host_raddr = 4'd6;
    #1;
    check("rd4_resp", 32'(host_rd_resp_valid), 32'd1);
    check("rd4_new", host_rdata, 32'hC0A8_0000);
    tick();
    host_raddr = 4'd9;
    #1;
    check("rd6", host_rdata, 32'h0000_1F90);
    tick();
    host_rd_valid = 1'b0;
    #1;
    check("rd_oor", host_rdata, 32'hDEAD_BEEF);
    check("rd_oor_resp", 32'(host_rd_resp_valid), 32'd1);
    tick();
    #1;
    check("rd_idle_resp", 32'(host_rd_resp_valid), 32'd0);

    // Re-boot with address 3 corrupted on readback.
    corrupt = 1'b1; boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    boot_run(14);
    #1;
    check("cor_done", 32'(boot_done), 32'd1);
    check("cor_err", 32'(boot_err), 32'd1);
    check("cor_eaddr", 32'(err_addr), 32'd3);
    corrupt = 1'b0; boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    #1;
    check("clr_err", 32'(boot_err), 32'd0);
    check("clr_eaddr", 32'(err_addr), 32'd0);
    check("clr_hold", 32'(filter_hold), 32'd1);

    // Reset asserted at cycle 9 (mid-verify), then a full boot again.
    boot_run(9);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    tick();
    rst_n = 1'b1;
    boot_run(14);
    #1;
    check("rb_done", 32'(boot_done), 32'd1);
    check("rb_err", 32'(boot_err), 32'd0);
    host_rd_valid = 1'b1; host_raddr = 4'd4;
    tick();
    host_rd_valid = 1'b0;
    #1;
    check("rb_rd4", host_rdata, 32'h0A00_0100);

`ifdef CFG_WRITE_LOCK_EN
    host_wr_valid = 1'b1; host_waddr = 4'hF; host_wdata = 32'h1;
    #1;
    check("lk_set_we", 32'(cfg_we), 32'd1);
    tick();
    host_waddr = 4'd0; host_wdata = 32'h1234_5678;
    #1;
    check("lk_we", 32'(cfg_we), 32'd0);
    check("lk_wrdy", 32'(host_wr_ready), 32'd1);
    tick();
    host_wr_valid = 1'b0;
    #1;
    check("lk_cnt", 32'(lock_drop_cnt), 32'd1);
    host_rd_valid = 1'b1; host_raddr = 4'd0;
    tick();
    host_raddr = 4'hF;
    #1;
    check("lk_rd0", host_rdata, 32'hDEAD_BEEF);
    tick();
    host_rd_valid = 1'b0;
    #1;
    check("lk_rdf", host_rdata, 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
